// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32I opcode constants, immediate formats and decode defaults
package rv_decode_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // IMM_X marks an opcode outside the base set
  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_X} imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:                       return IMM_R;
      OPC_OPIMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                    return IMM_S;
      OPC_BRANCH:                   return IMM_B;
      OPC_LUI, OPC_AUIPC:           return IMM_U;
      OPC_JAL:                      return IMM_J;
      default:                      return IMM_X;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// rtl/decode_issue_stage_if.sv - fetch-side and ID/EX-side handshakes of the decode/issue stage
interface decode_issue_stage_if
  import rv_decode_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = $clog2(NREGS_DEF)
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [XLEN-1:0] out_imm;
  logic [RAW-1:0]  out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic            out_writes_rd;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd,
           out_opcode, out_funct3, out_funct7b5, out_writes_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd,
           out_opcode, out_funct3, out_funct7b5, out_writes_rd, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - classifies the instruction format and builds the sign-extended immediate
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o
);
  logic [31:0] imm32;

  always_comb begin
    type_o = imm_type_of(instr_i[6:0]);
    imm32  = '0;
    case (type_o)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_o = XLEN'($signed(imm32));
  end
endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - RV32I decode/issue: operand fetch with writeback bypass,
// busy-scoreboard interlock and the ID/EX pipeline register
module decode_issue_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  decode_issue_stage_if.slave bus,
  output logic [RAW-1:0]  rf_addr1,
  output logic [RAW-1:0]  rf_addr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);
  logic [31:0]     instr;
  logic [RAW-1:0]  rs1, rs2, rd;
  imm_type_e       itype;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  logic            uses_rs1, uses_rs2, writes_rd, illegal, hazard, fire_in, fire_out;
  logic [NREGS-1:0] busy_q, busy_d, wb_mask, eff_busy;

  logic            out_valid_q, out_funct7b5_q, out_writes_rd_q, out_illegal_q;
  logic [XLEN-1:0] out_pc_q, out_rs1_q, out_rs2_q, out_imm_q;
  logic [RAW-1:0]  out_rd_q;
  logic [6:0]      out_opcode_q;
  logic [2:0]      out_funct3_q;

  assign instr    = bus.in_instr;
  assign rs1      = RAW'(instr[19:15]);
  assign rs2      = RAW'(instr[24:20]);
  assign rd       = RAW'(instr[11:7]);
  assign rf_addr1 = rs1;
  assign rf_addr2 = rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr_i(instr), .imm_o(imm), .type_o(itype));

  assign uses_rs1  = itype inside {IMM_R, IMM_I, IMM_S, IMM_B};
  assign uses_rs2  = itype inside {IMM_R, IMM_S, IMM_B};
  assign illegal   = (itype == IMM_X);
  assign writes_rd = (itype inside {IMM_R, IMM_I, IMM_U, IMM_J}) && (rd != '0);

  // a register being written back this cycle is already readable through the bypass
  assign wb_mask  = wb_en ? (NREGS'(1) << wb_addr) : '0;
  assign eff_busy = busy_q & ~wb_mask;
  assign hazard   = (uses_rs1 & eff_busy[rs1]) | (uses_rs2 & eff_busy[rs2]) | (writes_rd & eff_busy[rd]);

  assign bus.in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | bus.out_ready);
  assign fire_in      = bus.in_valid & bus.in_ready;
  assign fire_out     = out_valid_q & bus.out_ready;

  always_comb begin
    rs1_val = rf_data1;
    if (rs1 == '0) rs1_val = '0;
    else if (wb_en && wb_addr == rs1) rs1_val = wb_data;
    rs2_val = rf_data2;
    if (rs2 == '0) rs2_val = '0;
    else if (wb_en && wb_addr == rs2) rs2_val = wb_data;
  end

  // clears first so a same-cycle issue to the same register keeps it busy
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (flush && out_valid_q && out_writes_rd_q && !fire_out) busy_d[out_rd_q] = 1'b0;
    if (fire_in && writes_rd) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      out_valid_q     <= 1'b0;
      out_pc_q        <= '0;
      out_rs1_q       <= '0;
      out_rs2_q       <= '0;
      out_imm_q       <= '0;
      out_rd_q        <= '0;
      out_opcode_q    <= '0;
      out_funct3_q    <= '0;
      out_funct7b5_q  <= 1'b0;
      out_writes_rd_q <= 1'b0;
      out_illegal_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (fire_in) begin
        out_valid_q     <= 1'b1;
        out_pc_q        <= bus.in_pc;
        out_rs1_q       <= rs1_val;
        out_rs2_q       <= rs2_val;
        out_imm_q       <= imm;
        out_rd_q        <= rd;
        out_opcode_q    <= instr[6:0];
        out_funct3_q    <= instr[14:12];
        out_funct7b5_q  <= instr[30];
        out_writes_rd_q <= writes_rd;
        out_illegal_q   <= illegal;
      end else if (flush || fire_out) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_pc_q;
  assign bus.out_rs1_val   = out_rs1_q;
  assign bus.out_rs2_val   = out_rs2_q;
  assign bus.out_imm       = out_imm_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_opcode    = out_opcode_q;
  assign bus.out_funct3    = out_funct3_q;
  assign bus.out_funct7b5  = out_funct7b5_q;
  assign bus.out_writes_rd = out_writes_rd_q;
  assign bus.out_illegal   = out_illegal_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - vector table, hand sequences and randomized model check of decode_issue_stage
module tb_decode_issue_stage;
  logic        clk;
  logic        rst, flush, wb_en;
  logic [4:0]  wb_addr, rf_addr1, rf_addr2;
  logic [31:0] wb_data, rf_data1, rf_data2;
  logic [31:0] regs [32];

  decode_issue_stage_if bus ();

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: async read, written on writeback edges; x0 deliberately holds garbage
  assign rf_data1 = regs[rf_addr1];
  assign rf_data2 = regs[rf_addr2];
  always @(posedge clk) if (wb_en) regs[wb_addr] <= wb_data;

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, wr, ill, u1, u2;
  } bundle_t;

  typedef struct {
    logic [31:0] instr, imm;
    logic        wr, ill;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  int pending [$];
  int exq [$];
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return regs[r];
  endfunction

  // immediates rebuilt with signed arithmetic shifts and weighted field sums
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    int s, hi, fmt;
    s = ins;
    case (ins[6:0])
      7'h33:               fmt = 1;
      7'h13, 7'h03, 7'h67: fmt = 2;
      7'h23:               fmt = 3;
      7'h63:               fmt = 4;
      7'h37, 7'h17:        fmt = 5;
      7'h6F:               fmt = 6;
      default:             fmt = 0;
    endcase
    b.imm = 32'd0;
    case (fmt)
      2: begin hi = s >>> 20; b.imm = hi; end
      3: begin hi = s >>> 25; b.imm = (hi << 5) | 32'(ins[11:7]); end
      4: begin hi = s >>> 31;
         b.imm = (hi << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
      5: b.imm = ins & 32'hFFFF_F000;
      6: begin hi = s >>> 31;
         b.imm = (hi << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
      default: b.imm = 32'd0;
    endcase
    b.pc   = pc;
    b.rd   = ins[11:7];
    b.rs1  = ins[19:15];
    b.rs2  = ins[24:20];
    b.opc  = ins[6:0];
    b.f3   = ins[14:12];
    b.f7b5 = ins[30];
    b.u1   = (fmt >= 1 && fmt <= 4);
    b.u2   = (fmt == 1 || fmt == 3 || fmt == 4);
    b.wr   = (fmt == 1 || fmt == 2 || fmt == 5 || fmt == 6) && (b.rd != 5'd0);
    b.ill  = (fmt == 0);
    b.rs1v = opnd(b.rs1);
    b.rs2v = opnd(b.rs2);
    return b;
  endfunction

  function automatic bit busy_eff(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (wb_en && wb_addr == r) return 1'b0;
    foreach (pending[i]) if (pending[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hazard_of(input bundle_t b);
    return (b.u1 && busy_eff(b.rs1)) || (b.u2 && busy_eff(b.rs2)) || (b.wr && busy_eff(b.rd));
  endfunction

  function automatic void drop(input int r);
    for (int i = pending.size() - 1; i >= 0; i--) if (pending[i] == r) pending.delete(i);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h37;  6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;  default: w[6:0] = 7'h7F;
    endcase
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic check_out(input bundle_t e, input string tag);
    chk({tag, "_pc"},   bus.out_pc, e.pc);
    chk({tag, "_rs1v"}, bus.out_rs1_val, e.rs1v);
    chk({tag, "_rs2v"}, bus.out_rs2_val, e.rs2v);
    if (!e.ill) chk({tag, "_imm"}, bus.out_imm, e.imm);
    chk({tag, "_rd"},   32'(bus.out_rd), 32'(e.rd));
    chk({tag, "_opc"},  32'(bus.out_opcode), 32'(e.opc));
    chk({tag, "_f3"},   32'(bus.out_funct3), 32'(e.f3));
    chk({tag, "_f7b5"}, 32'(bus.out_funct7b5), 32'(e.f7b5));
    chk({tag, "_wr"},   32'(bus.out_writes_rd), 32'(e.wr));
    chk({tag, "_ill"},  32'(bus.out_illegal), 32'(e.ill));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b1;
    flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0050_0093;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bundle_t e, b, m_b;
    bit m_valid, have, exp_rdy, fi, fo;
    logic [31:0] cur_instr, cur_pc;

    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i) * 32'h111;
    tbl.push_back('{32'h0050_0093, 32'h0000_0005, 1'b1, 1'b0});
    tbl.push_back('{32'h0010_0013, 32'h0000_0001, 1'b0, 1'b0});
    tbl.push_back('{32'h0000_0FFF, 32'h0000_0000, 1'b0, 1'b1});
    tbl.push_back('{32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0, 1'b0});
    tbl.push_back('{32'h0010_00EF, 32'h0000_0800, 1'b1, 1'b0});
    tbl.push_back('{32'h1234_52B7, 32'h1234_5000, 1'b1, 1'b0});
    tbl.push_back('{32'hFE20_AC23, 32'hFFFF_FFF8, 1'b0, 1'b0});
    tbl.push_back('{32'hFFF1_00E7, 32'hFFFF_FFFF, 1'b1, 1'b0});
    tbl.push_back('{32'h0000_1017, 32'h0000_1000, 1'b0, 1'b0});
    tbl.push_back('{32'h7FF1_A383, 32'h0000_07FF, 1'b1, 1'b0});

    idle_inputs();
    rst = 1'b1;
    step();
    do_reset();
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_pc", bus.out_pc, 32'd0);
    chk("reset_out_imm", bus.out_imm, 32'd0);
    chk("reset_out_rs1", bus.out_rs1_val, 32'd0);
    chk("reset_out_rd", 32'(bus.out_rd), 32'd0);
    chk("reset_out_wr", 32'(bus.out_writes_rd), 32'd0);
    step();

    foreach (tbl[i]) begin
      do_reset();
      bus.in_valid = 1'b1; bus.in_instr = tbl[i].instr; bus.in_pc = 32'h1000 + 32'(i) * 4;
      @(negedge clk);
      chk("tbl_in_ready", 32'(bus.in_ready), 32'd1);
      e = ref_decode(tbl[i].instr, bus.in_pc);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_out_valid", 32'(bus.out_valid), 32'd1);
      if (!tbl[i].ill) chk("tbl_imm", bus.out_imm, tbl[i].imm);
      chk("tbl_writes_rd", 32'(bus.out_writes_rd), 32'(tbl[i].wr));
      chk("tbl_illegal", 32'(bus.out_illegal), 32'(tbl[i].ill));
      check_out(e, "tbl");
    end

    // RAW interlock released by writeback bypass, then backpressure without bubble
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'h100;
    step();
    bus.in_instr = 32'h0010_8133; bus.in_pc = 32'h104;
    @(negedge clk);
    chk("raw_addi_valid", 32'(bus.out_valid), 32'd1);
    chk("raw_addi_imm", bus.out_imm, 32'd5);
    chk("raw_addi_rd", 32'(bus.out_rd), 32'd1);
    chk("raw_stall0", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("raw_stall1", 32'(bus.in_ready), 32'd0);
    chk("raw_bubble_valid", 32'(bus.out_valid), 32'd0);
    step();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    @(negedge clk);
    chk("raw_wb_ready", 32'(bus.in_ready), 32'd1);
    step();
    wb_en = 1'b0;
    bus.in_instr = 32'h0070_0193; bus.in_pc = 32'h108; bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_rd", 32'(bus.out_rd), 32'd2);
      chk("bp_rs1v", bus.out_rs1_val, 32'd5);
      chk("bp_rs2v", bus.out_rs2_val, 32'd5);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      if (k < 3) step();
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_rd", 32'(bus.out_rd), 32'd3);
    chk("bp_next_imm", bus.out_imm, 32'd7);
    step();
    @(negedge clk);
    chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);
    step();

    // flush of an unaccepted lui x5 frees x5
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h1234_52B7; bus.in_pc = 32'h200;
    step();
    bus.in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_held_valid", 32'(bus.out_valid), 32'd1);
    chk("flush_held_rd", 32'(bus.out_rd), 32'd5);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0002_8313; bus.in_pc = 32'h204;
    @(negedge clk);
    chk("flush_killed_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_x5_free", 32'(bus.in_ready), 32'd1);
    e = ref_decode(32'h0002_8313, 32'h204);
    step();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_reader_valid", 32'(bus.out_valid), 32'd1);
    check_out(e, "flush_reader");
    step();

    // flush blocks accept; x0 destination never interlocks
    do_reset();
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0010_0013; bus.in_pc = 32'h300;
    @(negedge clk);
    chk("flush_no_accept", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("x0_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_instr = 32'h0000_01B3; bus.in_pc = 32'h304;
    @(negedge clk);
    chk("x0_writes_rd", 32'(bus.out_writes_rd), 32'd0);
    chk("x0_reader_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("x0_reader_rd", 32'(bus.out_rd), 32'd3);
    chk("x0_reads_zero", bus.out_rs1_val, 32'd0);
    step();

    // randomized run against the reference model, including mid-stream resets
    m_valid = 1'b0; have = 1'b0; cur_instr = 32'd0; cur_pc = 32'd0;
    pending.delete(); exq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
      if (!have) begin
        cur_instr = rand_instr();
        cur_pc    = $urandom & 32'hFFFF_FFFC;
        have      = ($urandom_range(0, 3) != 0);
      end
      bus.in_valid = have; bus.in_instr = cur_instr; bus.in_pc = cur_pc;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if (exq.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_en = 1'b1; wb_addr = 5'(exq.pop_front()); wb_data = $urandom;
      end else begin
        wb_en = 1'b0; wb_addr = 5'($urandom); wb_data = $urandom;
      end
      @(negedge clk);
      b = ref_decode(cur_instr, cur_pc);
      exp_rdy = !rst && !flush && !hazard_of(b) && (!m_valid || bus.out_ready);
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (cyc > 0) begin
        chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) check_out(m_b, "rnd");
      end
      fi = have && exp_rdy;
      fo = m_valid && bus.out_ready;
      if (rst) begin
        m_valid = 1'b0;
        pending.delete();
        exq.delete();
      end else begin
        if (wb_en) drop(int'(wb_addr));
        if (flush && m_valid && m_b.wr && !fo) drop(int'(m_b.rd));
        if (fo && m_b.wr) exq.push_back(int'(m_b.rd));
        if (fi) begin
          if (b.wr) pending.push_back(int'(b.rd));
          m_b = b;
          m_valid = 1'b1;
        end else if (flush || fo) begin
          m_valid = 1'b0;
        end
      end
      if (fi) have = 1'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
